multicycle_control_unit: RTL

//  Multicycle CPU control FSM for the 16-bit core; decodes {command,ext} opcode and sequences datapath strobes.

---
 rtl/multicycle_control_unit.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 16-bit core: decodes {command,ext} and sequences datapath strobes.
// Optional macro STK_GUARD_EN traps PUSH on a full stack / POP on an empty stack into FAULT.
module multicycle_control_unit #(
    parameter int CMD_W      = 6,
    parameter int FUNC_W     = 5,
    parameter int FLAGS_size = 6,
    parameter int WAIT_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic [CMD_W:0]        opcode,
    input  logic                  state_flag_bit,
    input  logic                  mem_rdy,
    input  logic                  stk_pop_valid,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic                  wrmem,
    output logic                  ioe,
    output logic                  intreq,
    output logic                  decodeinstr,
    output logic                  we3,
    output logic                  rst,
    output logic                  hlt,
    output logic                  wrpc,
    output logic                  prefix,
    output logic                  jump,
    output logic                  ch,
    output logic                  ret,
    output logic                  wrflags,
    output logic                  seladdr,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  fault,
    output logic [FLAGS_size-1:0] Jcc,
    output logic [FUNC_W-1:0]     func,
    output logic [2:0]            stwr,
    output logic [1:0]            spc_a,
    output logic [2:0]            spc_b,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_PCINC   = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_ALU, K_CMP, K_MOV, K_RST, K_INT, K_HLT, K_MEM,
        K_J, K_JCC, K_CH, K_RET, K_PUSH, K_POP
    } kind_t;

    localparam int C_LDW = 0,  C_STW = 1,  C_MOV = 2,  C_HLT = 3,  C_RST = 4,  C_INT = 5;
    localparam int C_IN  = 6,  C_OUT = 7,  C_CH  = 8,  C_RET = 9,  C_ADD = 10, C_SUB = 11;
    localparam int C_MUL = 12, C_DIV = 13, C_MVN = 14, C_OR  = 15, C_AND = 16, C_ORN = 17;
    localparam int C_ANDN = 18, C_EOR = 19, C_EON = 20, C_LSL = 21, C_LSR = 22, C_ASR = 23;
    localparam int C_REV = 24, C_J   = 25, C_JZ  = 26, C_JNZ = 27, C_JC  = 28, C_JNC = 29;
    localparam int C_JO  = 30, C_JNO = 31, C_JP  = 32, C_JNP = 33, C_JG  = 34, C_JL  = 35;
    localparam int C_JNG = 36, C_JNL = 37, C_CMP = 38, C_MOD = 39, C_PUSH = 40, C_POP = 41;

    localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_MUL  = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_DIV  = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_MOD  = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_MVN  = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_ORN  = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_ANDN = FUNC_W'(9);
    localparam logic [FUNC_W-1:0] F_EOR  = FUNC_W'(10);
    localparam logic [FUNC_W-1:0] F_EON  = FUNC_W'(11);
    localparam logic [FUNC_W-1:0] F_REV  = FUNC_W'(12);
    localparam logic [FUNC_W-1:0] F_LSL  = FUNC_W'(13);
    localparam logic [FUNC_W-1:0] F_LSR  = FUNC_W'(14);
    localparam logic [FUNC_W-1:0] F_ASR  = FUNC_W'(15);
    localparam logic [FUNC_W-1:0] F_NOP  = FUNC_W'(16);
    localparam logic [FUNC_W-1:0] F_CMP  = FUNC_W'(17);

    localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    state_t              r_state;
    state_t              w_state_next;
    logic [CMD_W:0]      r_opc_q;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [WCNT_W-1:0]   w_wait_cnt_next;
    logic [31:0]         w_cmd;
    logic                w_ext;
    kind_t               w_kind;
    logic [FUNC_W-1:0]   w_alu_func;
    logic [FLAGS_size-1:0] w_jcc_idx;
    logic                w_jcc_neg;
    logic                w_wait_expired;

    assign w_cmd   = 32'(r_opc_q[CMD_W:1]);
    assign w_ext   = r_opc_q[0];
    assign state_o = r_state;

    // Last permitted waiting cycle; WAIT_MAX of zero disables the watchdog.
    assign w_wait_expired = (WAIT_MAX != 0) && (r_wait_cnt == WAIT_LAST);

    assign w_jcc_neg = (w_cmd == C_JNZ) || (w_cmd == C_JNC) || (w_cmd == C_JNO) ||
                       (w_cmd == C_JNP) || (w_cmd == C_JNG) || (w_cmd == C_JNL);

`ifndef STK_GUARD_EN
    logic w_unused_stk;
    assign w_unused_stk = stk_full | stk_empty;
`endif

    always_comb begin
        w_kind     = K_NOP;
        w_alu_func = F_NOP;
        w_jcc_idx  = '0;
        case (w_cmd)
            C_LDW, C_STW, C_IN, C_OUT: w_kind = K_MEM;
            C_MOV:  w_kind = K_MOV;
            C_HLT:  w_kind = K_HLT;
            C_RST:  w_kind = K_RST;
            C_INT:  w_kind = K_INT;
            C_CH:   w_kind = K_CH;
            C_RET:  w_kind = K_RET;
            C_J:    w_kind = K_J;
            C_CMP:  w_kind = K_CMP;
            C_PUSH: w_kind = K_PUSH;
            C_POP:  w_kind = K_POP;
            C_ADD:  begin w_kind = K_ALU; w_alu_func = F_ADD;  end
            C_SUB:  begin w_kind = K_ALU; w_alu_func = F_SUB;  end
            C_MUL:  begin w_kind = K_ALU; w_alu_func = F_MUL;  end
            C_DIV:  begin w_kind = K_ALU; w_alu_func = F_DIV;  end
            C_MOD:  begin w_kind = K_ALU; w_alu_func = F_MOD;  end
            C_MVN:  begin w_kind = K_ALU; w_alu_func = F_MVN;  end
            C_OR:   begin w_kind = K_ALU; w_alu_func = F_OR;   end
            C_AND:  begin w_kind = K_ALU; w_alu_func = F_AND;  end
            C_ORN:  begin w_kind = K_ALU; w_alu_func = F_ORN;  end
            C_ANDN: begin w_kind = K_ALU; w_alu_func = F_ANDN; end
            C_EOR:  begin w_kind = K_ALU; w_alu_func = F_EOR;  end
            C_EON:  begin w_kind = K_ALU; w_alu_func = F_EON;  end
            C_REV:  begin w_kind = K_ALU; w_alu_func = F_REV;  end
            C_LSL:  begin w_kind = K_ALU; w_alu_func = F_LSL;  end
            C_LSR:  begin w_kind = K_ALU; w_alu_func = F_LSR;  end
            C_ASR:  begin w_kind = K_ALU; w_alu_func = F_ASR;  end
            C_JZ, C_JNZ: begin w_kind = K_JCC; w_jcc_idx = FLAGS_size'(5); end
            C_JC, C_JNC: begin w_kind = K_JCC; w_jcc_idx = FLAGS_size'(3); end
            C_JO, C_JNO: begin w_kind = K_JCC; w_jcc_idx = FLAGS_size'(4); end
            C_JP, C_JNP: begin w_kind = K_JCC; w_jcc_idx = FLAGS_size'(2); end
            C_JG, C_JNG: begin w_kind = K_JCC; w_jcc_idx = FLAGS_size'(1); end
            C_JL, C_JNL: begin w_kind = K_JCC; w_jcc_idx = FLAGS_size'(0); end
            default: w_kind = K_NOP;
        endcase
    end

    always_comb begin
        wrmem = 1'b0; ioe = 1'b0; intreq = 1'b0; decodeinstr = 1'b0;
        we3 = 1'b0; rst = 1'b0; hlt = 1'b0; wrpc = 1'b0;
        prefix = 1'b0; jump = 1'b0; ch = 1'b0; ret = 1'b0;
        wrflags = 1'b0; seladdr = 1'b0; stk_push = 1'b0; stk_pop = 1'b0;
        fault = 1'b0;
        Jcc   = '0;
        func  = F_NOP;
        stwr  = 3'd0;
        spc_a = 2'd0;
        spc_b = 3'd0;
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        if (init) begin
            rst             = 1'b1;
            w_state_next    = S_FETCH;
            w_wait_cnt_next = '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    decodeinstr  = 1'b1;
                    w_state_next = S_DECODE;
                end
                S_DECODE: begin
                    spc_a = 2'd1; spc_b = 3'd2; func = F_ADD;
                    w_state_next = S_PCINC;
                end
                S_PCINC: begin
                    wrpc = 1'b1; spc_a = 2'd1; spc_b = 3'd2; func = F_ADD;
                    w_state_next = S_EXEC;
                end
                S_EXEC: begin
                    w_wait_cnt_next = '0;
                    w_state_next    = S_FETCH;
                    case (w_kind)
                        K_ALU: begin
                            spc_b = {2'b00, w_ext}; func = w_alu_func;
                            wrflags = 1'b1; we3 = 1'b1;
                        end
                        K_CMP: begin func = F_CMP; wrflags = 1'b1; end
                        K_MOV: begin we3 = 1'b1; stwr = w_ext ? 3'd1 : 3'd2; end
                        K_RST: rst = 1'b1;
                        K_INT: intreq = 1'b1;
                        K_HLT: w_state_next = S_HALT;
                        K_MEM: begin seladdr = 1'b1; w_state_next = S_MEMWAIT; end
                        K_J:   begin jump = 1'b1; prefix = w_ext; wrpc = 1'b1; end
                        K_JCC: begin
                            jump = 1'b1; prefix = w_ext; Jcc = w_jcc_idx;
                            w_state_next = S_WB;
                        end
                        // Link register is written now; the PC load happens in WB.
                        K_CH: begin
                            ch = 1'b1; jump = 1'b1; prefix = w_ext; we3 = 1'b1;
                            w_state_next = S_WB;
                        end
                        K_RET: begin ret = 1'b1; jump = 1'b1; w_state_next = S_WB; end
                        K_PUSH: begin
`ifdef STK_GUARD_EN
                            if (stk_full) w_state_next = S_FAULT;
                            else          stk_push = 1'b1;
`else
                            stk_push = 1'b1;
`endif
                        end
                        K_POP: begin
`ifdef STK_GUARD_EN
                            if (stk_empty) begin
                                w_state_next = S_FAULT;
                            end else begin
                                stk_pop = 1'b1; w_state_next = S_WB;
                            end
`else
                            stk_pop = 1'b1; w_state_next = S_WB;
`endif
                        end
                        default: w_state_next = S_FETCH;
                    endcase
                end
                S_MEMWAIT: begin
                    seladdr = 1'b1;
                    if (mem_rdy) begin
                        w_state_next = S_FETCH;
                        case (w_cmd)
                            C_LDW:   begin we3 = 1'b1; stwr = 3'd3; end
                            C_STW:   wrmem = 1'b1;
                            C_OUT:   ioe = 1'b1;
                            C_IN:    begin ioe = 1'b1; we3 = 1'b1; stwr = 3'd4; end
                            default: wrmem = 1'b0;
                        endcase
                    end else if (w_wait_expired) begin
                        w_state_next = S_FAULT;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    w_state_next = S_FETCH;
                    case (w_kind)
                        K_JCC: begin
                            jump = 1'b1; prefix = w_ext; Jcc = w_jcc_idx;
                            wrpc = state_flag_bit ^ w_jcc_neg;
                        end
                        K_CH:  begin jump = 1'b1; prefix = w_ext; wrpc = 1'b1; end
                        K_RET: begin ret = 1'b1; jump = 1'b1; wrpc = 1'b1; end
                        K_POP: begin
                            if (stk_pop_valid) begin
                                we3 = 1'b1; stwr = 3'd3;
                            end else if (w_wait_expired) begin
                                w_state_next = S_FAULT;
                            end else begin
                                w_state_next    = S_WB;
                                w_wait_cnt_next = r_wait_cnt + 1'b1;
                            end
                        end
                        default: w_state_next = S_FETCH;
                    endcase
                end
                S_HALT:  hlt = 1'b1;
                S_FAULT: fault = 1'b1;
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            r_state    <= S_FETCH;
            r_opc_q    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (r_state == S_DECODE) r_opc_q <= opcode;
        end
    end

endmodule
